// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control unit: sequences fetch/decode/execute/memory/writeback,
// stalls on memReady in memory states and drives the multi-cycle datapath controls.
module mc_control_fsm #(
  parameter int unsigned ADDI_EN     = 1,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned STATE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opCode,
  input  logic               memReady,
  output logic               pcWrite,
  output logic               pcWriteCond,
  output logic               iorD,
  output logic               memRead,
  output logic               memWrite,
  output logic               irWrite,
  output logic               memtoReg,
  output logic               regDst,
  output logic               regWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         pcSource,
  output logic               instrDone,
  output logic               illegalOp,
  output logic               memTimeout,
  output logic [STATE_W-1:0] state
);

  localparam logic [3:0] StFetch  = 4'd0;
  localparam logic [3:0] StDecode = 4'd1;
  localparam logic [3:0] StMemAdr = 4'd2;
  localparam logic [3:0] StMemRd  = 4'd3;
  localparam logic [3:0] StMemWb  = 4'd4;
  localparam logic [3:0] StMemWr  = 4'd5;
  localparam logic [3:0] StRExec  = 4'd6;
  localparam logic [3:0] StRWb    = 4'd7;
  localparam logic [3:0] StBeq    = 4'd8;
  localparam logic [3:0] StJmp    = 4'd9;
  localparam logic [3:0] StAddiEx = 4'd10;
  localparam logic [3:0] StAddiWb = 4'd11;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam bit          AddiOn = (ADDI_EN != 0);
  localparam bit          WdogOn = (TIMEOUT_CYC != 0);
  localparam int unsigned CntW   = WdogOn ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC);

  logic [3:0]      state_q, state_d;
  logic [5:0]      op_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic            op_legal;
  logic            wait_st;
  logic            stalled;

  // Decoded controls before reset gating
  logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
  logic       memto_reg, reg_dst, reg_write, alu_src_a, instr_done;
  logic [1:0] alu_src_b, alu_op, pc_source;

  always_comb begin
    state_d  = state_q;
    op_legal = 1'b1;
    case (state_q)
      StFetch:  if (memReady) state_d = StDecode;
      StDecode: begin
        case (opCode)
          OpRType:    state_d = StRExec;
          OpLw, OpSw: state_d = StMemAdr;
          OpBeq:      state_d = StBeq;
          OpJ:        state_d = StJmp;
          OpAddi: begin
            if (AddiOn) begin
              state_d = StAddiEx;
            end else begin
              state_d  = StFetch;
              op_legal = 1'b0;
            end
          end
          default: begin
            state_d  = StFetch;
            op_legal = 1'b0;
          end
        endcase
      end
      // Registered opcode keeps lw/sw routing stable if IR changes after DECODE
      StMemAdr: state_d = (op_q == OpLw) ? StMemRd : StMemWr;
      StMemRd:  if (memReady) state_d = StMemWb;
      StMemWr:  if (memReady) state_d = StFetch;
      StRExec:  state_d = StRWb;
      StAddiEx: state_d = StAddiWb;
      StMemWb, StRWb, StAddiWb, StBeq, StJmp: state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  assign wait_st = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign stalled = wait_st && !memReady;

  always_comb begin
    cnt_d = '0;
    if (stalled) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    end
    // Set on the same edge the counter reaches the limit
    timeout_d = timeout_q | (WdogOn && stalled && (cnt_d == CntMax));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      op_q      <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      if (state_q == StDecode) op_q <= opCode;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ior_d         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    memto_reg     = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = memReady;
        pc_write  = memReady;
      end
      StDecode: alu_src_b = 2'b11;
      StMemAdr, StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StMemRd: begin
        mem_read = 1'b1;
        ior_d    = 1'b1;
      end
      StMemWr: begin
        mem_write  = 1'b1;
        ior_d      = 1'b1;
        instr_done = memReady;
      end
      StMemWb: begin
        memto_reg  = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      StRExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      StRWb: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      StAddiWb: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      StBeq: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      StJmp: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Gate with rst so no enable can be high while reset is asserted
  assign pcWrite     = ~rst & pc_write;
  assign pcWriteCond = ~rst & pc_write_cond;
  assign iorD        = ~rst & ior_d;
  assign memRead     = ~rst & mem_read;
  assign memWrite    = ~rst & mem_write;
  assign irWrite     = ~rst & ir_write;
  assign memtoReg    = ~rst & memto_reg;
  assign regDst      = ~rst & reg_dst;
  assign regWrite    = ~rst & reg_write;
  assign ALUSrcA     = ~rst & alu_src_a;
  assign ALUSrcB     = rst ? 2'b00 : alu_src_b;
  assign ALUOp       = rst ? 2'b00 : alu_op;
  assign pcSource    = rst ? 2'b00 : pc_source;
  assign instrDone   = ~rst & instr_done;
  assign illegalOp   = ~rst & (state_q == StDecode) & ~op_legal;
  assign memTimeout  = ~rst & timeout_q;
  assign state       = rst ? '0 : STATE_W'(state_q);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-cycle scoreboard of state/outputs plus
// instruction latency queue checked on each instrDone pulse.
module tb_mc_control_fsm;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3;
  localparam logic [3:0] MEMWB = 4'd4, MEMWR = 4'd5, REXEC = 4'd6, RWB = 4'd7;
  localparam logic [3:0] BEQ = 4'd8, JMP = 4'd9, ADDIEX = 4'd10, ADDIWB = 4'd11;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam int         TO_CYC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst2 = 1'b1;
  logic [5:0] opCode = 6'd0;
  logic [5:0] op2 = OP_ADDI;
  logic       memReady = 1'b0;

  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memtoReg, regDst;
  logic       regWrite, ALUSrcA, instrDone, illegalOp, memTimeout;
  logic [1:0] ALUSrcB, ALUOp, pcSource;
  logic [3:0] state;

  logic       pcWrite2, pcWriteCond2, iorD2, memRead2, memWrite2, irWrite2, memtoReg2;
  logic       regDst2, regWrite2, ALUSrcA2, instrDone2, illegalOp2, memTimeout2;
  logic [1:0] ALUSrcB2, ALUOp2, pcSource2;
  logic [3:0] state2;

  mc_control_fsm #(.ADDI_EN(1), .TIMEOUT_CYC(TO_CYC), .STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opCode(opCode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
    .memWrite(memWrite), .irWrite(irWrite), .memtoReg(memtoReg), .regDst(regDst),
    .regWrite(regWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .pcSource(pcSource), .instrDone(instrDone), .illegalOp(illegalOp),
    .memTimeout(memTimeout), .state(state)
  );

  mc_control_fsm #(.ADDI_EN(0), .TIMEOUT_CYC(TO_CYC), .STATE_W(4)) dut_noaddi (
    .clk(clk), .rst(rst2), .opCode(op2), .memReady(1'b1),
    .pcWrite(pcWrite2), .pcWriteCond(pcWriteCond2), .iorD(iorD2), .memRead(memRead2),
    .memWrite(memWrite2), .irWrite(irWrite2), .memtoReg(memtoReg2), .regDst(regDst2),
    .regWrite(regWrite2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ALUOp(ALUOp2),
    .pcSource(pcSource2), .instrDone(instrDone2), .illegalOp(illegalOp2),
    .memTimeout(memTimeout2), .state(state2)
  );

  always #5 clk = ~clk;

  logic [15:0] obs, obs2;
  assign obs  = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memtoReg, regDst,
                 regWrite, ALUSrcA, ALUSrcB, ALUOp, pcSource, instrDone};
  assign obs2 = {pcWrite2, pcWriteCond2, iorD2, memRead2, memWrite2, irWrite2, memtoReg2,
                 regDst2, regWrite2, ALUSrcA2, ALUSrcB2, ALUOp2, pcSource2, instrDone2};

  typedef struct {
    logic [3:0]  st;
    logic [15:0] outv;
    logic        ill;
    logic        to;
  } exp_t;

  exp_t sb_q[$];
  int   lat_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   wait_run = 0;
  logic exp_to = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected control vector straight from the state output table
  function automatic logic [15:0] exp_out(input logic [3:0] s, input logic mr);
    logic pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, done;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, done} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (s)
      FETCH:          begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      DECODE:         asb = 2'b11;
      MEMADR, ADDIEX: begin asa = 1; asb = 2'b10; end
      MEMRD:          begin mrd = 1; iord = 1; end
      MEMWR:          begin mwr = 1; iord = 1; done = mr; end
      MEMWB:          begin m2r = 1; rw = 1; done = 1; end
      REXEC:          begin asa = 1; aop = 2'b10; end
      RWB:            begin rdst = 1; rw = 1; done = 1; end
      ADDIWB:         begin rw = 1; done = 1; end
      BEQ:            begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; done = 1; end
      JMP:            begin pw = 1; psrc = 2'b10; done = 1; end
      default: ;
    endcase
    return {pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, done};
  endfunction

  // One clock: called at posedge+1, drives memReady, checks at negedge, returns at posedge+1
  task automatic step(input logic [3:0] st, input logic mr, input logic ill);
    exp_t e;
    int   l;
    memReady = mr;
    e.st = st; e.outv = exp_out(st, mr); e.ill = ill; e.to = exp_to;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    cyc++;
    check("state", 32'(state), 32'(e.st));
    check("outputs", 32'(obs), 32'(e.outv));
    check("illegalOp", 32'(illegalOp), 32'(e.ill));
    check("memTimeout", 32'(memTimeout), 32'(e.to));
    if (instrDone) begin
      if (lat_q.size() == 0) begin
        check("stray_instrDone", 32'(instrDone), 32'd0);
      end else begin
        l = lat_q.pop_front();
        check("latency", cyc, l);
      end
    end
    if ((st == FETCH || st == MEMRD || st == MEMWR) && !mr) begin
      wait_run++;
      if (wait_run >= TO_CYC) exp_to = 1'b1;
    end else begin
      wait_run = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int lat);
    logic ill;
    ill = !(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
    opCode = op;
    cyc = 0;
    if (lat > 0) lat_q.push_back(lat);
    for (int i = 0; i < fw; i++) step(FETCH, 1'b0, 1'b0);
    step(FETCH, 1'b1, 1'b0);
    step(DECODE, rnd1(), ill);
    opCode = 6'($urandom);
    case (op)
      OP_R:    begin step(REXEC, rnd1(), 1'b0); step(RWB, rnd1(), 1'b0); end
      OP_LW: begin
        step(MEMADR, rnd1(), 1'b0);
        for (int i = 0; i < mw; i++) step(MEMRD, 1'b0, 1'b0);
        step(MEMRD, 1'b1, 1'b0);
        step(MEMWB, rnd1(), 1'b0);
      end
      OP_SW: begin
        step(MEMADR, rnd1(), 1'b0);
        for (int i = 0; i < mw; i++) step(MEMWR, 1'b0, 1'b0);
        step(MEMWR, 1'b1, 1'b0);
      end
      OP_BEQ:  step(BEQ, rnd1(), 1'b0);
      OP_J:    step(JMP, rnd1(), 1'b0);
      OP_ADDI: begin step(ADDIEX, rnd1(), 1'b0); step(ADDIWB, rnd1(), 1'b0); end
      default: ;
    endcase
    if (lat > 0) check("done_count", lat_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_outputs", 32'(obs), 32'd0);
    check("rst_timeout", 32'(memTimeout), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Zero-wait latencies
    run_instr(OP_R, 0, 0, 4);
    run_instr(OP_LW, 0, 0, 5);
    run_instr(OP_SW, 0, 0, 4);
    run_instr(OP_BEQ, 0, 0, 3);
    run_instr(OP_J, 0, 0, 3);
    run_instr(OP_ADDI, 0, 0, 4);
    // Stalled lw, illegal opcode, stalled sw
    run_instr(OP_LW, 3, 2, 10);
    run_instr(OP_BAD, 0, 0, 0);
    run_instr(OP_SW, 0, 2, 6);
    run_instr(OP_BEQ, 1, 0, 4);

    // Asynchronous reset while waiting in MEMRD
    opCode = OP_LW;
    cyc = 0;
    step(FETCH, 1'b1, 1'b0);
    step(DECODE, 1'b1, 1'b0);
    step(MEMADR, 1'b0, 1'b0);
    step(MEMRD, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_outputs", 32'(obs), 32'd0);
    @(negedge clk);
    check("arst_hold_outputs", 32'(obs), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_run = 0;
    exp_to = 1'b0;
    run_instr(OP_J, 0, 0, 3);

    // Watchdog: 10 wait cycles in FETCH, then sticky until rst
    run_instr(OP_R, 10, 0, 14);
    run_instr(OP_BEQ, 0, 0, 3);
    rst = 1'b1;
    #1 check("wdog_cleared", 32'(memTimeout), 32'd0);

    // ADDI_EN=0 variant while the main DUT is held in reset
    @(posedge clk);
    #1 rst2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("noaddi_state", 32'(state2), (k % 2 == 1) ? 32'(DECODE) : 32'(FETCH));
      check("noaddi_illegal", 32'(illegalOp2), (k % 2 == 1) ? 32'd1 : 32'd0);
      check("noaddi_outputs", 32'(obs2), 32'(exp_out((k % 2 == 1) ? DECODE : FETCH, 1'b1)));
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    wait_run = 0;
    exp_to = 1'b0;
    run_instr(OP_ADDI, 0, 0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multi-cycle MIPS main control unit. It replaces the single-cycle opcode decoder with a state machine that sequences fetch, decode, execute, memory and writeback over several clocks. Memory-access states stall on a cache ready handshake. It drives the multi-cycle datapath muxes and enables, and it flags illegal opcodes and stalled memory.

Parameters:
ADDI_EN, 1, 1 = addi (opcode 001000) supported; 0 = addi treated as illegal
TIMEOUT_CYC, 255, max consecutive wait cycles in a memory state before memTimeout sets; 0 disables the watchdog
STATE_W, 4, width of the state debug output (min 4)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
opCode  in  6  instruction[31:26] from IR, sampled in DECODE
memReady  in  1  cache/memory completes the current access this cycle
pcWrite  out  1  unconditional PC write enable
pcWriteCond  out  1  PC write enable if ALU zero
iorD  out  1  memory address mux: 0 = PC, 1 = ALUOut
memRead  out  1  memory read request
memWrite  out  1  memory write request
irWrite  out  1  instruction register load
memtoReg  out  1  writeback mux: 1 = MDR
regDst  out  1  1 = rd, 0 = rt
regWrite  out  1  register file write
ALUSrcA  out  1  0 = PC, 1 = A
ALUSrcB  out  2  00 = B, 01 = 4, 10 = signext imm, 11 = signext imm<<2
ALUOp  out  2  00 add, 01 sub, 10 funct-decode
pcSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
instrDone  out  1  one-cycle pulse in the final cycle of each instruction
illegalOp  out  1  one-cycle pulse in DECODE for an unsupported opcode
memTimeout  out  1  sticky watchdog flag
state  out  STATE_W  current state encoding

Behaviour:
- Reset: clk and rst as named. rst=1 asynchronously forces state=FETCH, the wait counter to 0 and memTimeout to 0. All outputs are 0 while rst=1. The first FETCH cycle follows rst deassertion.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BEQ=8, JMP=9, ADDIEX=10, ADDIWB=11. Codes 12-15 recover to FETCH with all outputs 0.
- Outputs are decoded from state. Any output not listed for a state is 0.
  - FETCH: memRead=1, ALUSrcB=01. irWrite=pcWrite=memReady.
  - DECODE: ALUSrcB=11.
  - MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10.
  - MEMRD: memRead=1, iorD=1.
  - MEMWR: memWrite=1, iorD=1.
  - MEMWB: memtoReg=1, regWrite=1.
  - REXEC: ALUSrcA=1, ALUOp=10.
  - RWB: regDst=1, regWrite=1.
  - ADDIWB: regWrite=1.
  - BEQ: ALUSrcA=1, ALUOp=01, pcWriteCond=1, pcSource=01.
  - JMP: pcWrite=1, pcSource=10.
- Transitions:
  - FETCH→DECODE only when memReady=1; otherwise hold in FETCH.
  - DECODE dispatches on opCode: 000000→REXEC; 100011 or 101011→MEMADR; 000100→BEQ; 000010→JMP; 001000 with ADDI_EN=1→ADDIEX; anything else→FETCH with illegalOp=1.
  - MEMADR→MEMRD (lw) or MEMWR (sw). The opCode is registered in DECODE, so later IR changes are ignored.
  - MEMRD→MEMWB only when memReady=1; otherwise hold.
  - MEMWR→FETCH only when memReady=1; otherwise hold.
  - MEMWB, RWB, ADDIWB, BEQ, JMP→FETCH. REXEC→RWB. ADDIEX→ADDIWB.
- instrDone=1 in the cycles MEMWB, RWB, ADDIWB, BEQ and JMP, and in MEMWR when memReady=1.
- Latency with memReady held at 1: beq and j take 3 cycles; R-type, sw and addi take 4; lw takes 5. Each wait cycle adds one cycle.
- Watchdog:
  - The counter increments on each cycle spent in FETCH, MEMRD or MEMWR with memReady=0, saturating at TIMEOUT_CYC.
  - It clears on any memReady=1 cycle or on leaving the state.
  - When the counter reaches TIMEOUT_CYC (with TIMEOUT_CYC>0), memTimeout sets and stays set until rst.
  - The FSM keeps waiting after a timeout; it is never forced to advance.
- memReady is ignored outside FETCH, MEMRD and MEMWR.
- Reset mid-instruction aborts immediately. No register or memory enable may glitch high during rst.

Test Plan:
1. Reset: rst=1 mid-MEMRD → state=0 and all outputs 0 asynchronously. Release rst → FETCH with memRead=1 on the next cycle.
2. memReady tied 1, issue add, lw, sw, beq, j, addi → cycle counts 4, 5, 4, 3, 3, 4. Exactly one instrDone pulse per instruction. Per-state output values match the state table.
3. lw with memReady=0 for 3 cycles in FETCH and 2 in MEMRD → total 10 cycles. irWrite and pcWrite high only in the cycle memReady=1. No regWrite before MEMWB.
4. opCode=111111 → illegalOp pulses once in DECODE and the next state is FETCH. With ADDI_EN=0, opCode=001000 behaves the same way.
5. TIMEOUT_CYC=4, memReady=0 in FETCH for 10 cycles → memTimeout rises after the 4th wait cycle and stays high after memReady=1 returns. rst clears it.
6. sw with memReady=0 for 2 cycles in MEMWR → memWrite held high for 3 cycles, instrDone only in the final cycle, then FETCH.
